// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding and LCD byte constants for the frame streamer.
// Optional feature macro used by the slice: LCD_CURSOR_OFF_EN.
`default_nettype none

package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DISP_CMD = 3'd1,
        LINE_CMD = 3'd2,
        CHAR     = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [7:0] LCD_CMD_LINE0           = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE1           = 8'hC0;
    localparam logic [7:0] LCD_CMD_DISP_ON_CUR_OFF = 8'h0C;
    localparam logic [7:0] ASCII_SPACE             = 8'h20;

    function automatic logic [7:0] line_cmd(input logic row);
        return row ? LCD_CMD_LINE1 : LCD_CMD_LINE0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_refresh_timer.sv
// lcd_refresh_timer: free-running divider, one-cycle tick when the count wraps.
// REFRESH_DIV = 0 holds the counter at zero and never ticks.
`default_nettype none

module lcd_refresh_timer #(
    parameter int REFRESH_DIV = 5000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int              C_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [C_W-1:0]  C_LAST = C_W'((REFRESH_DIV > 0) ? REFRESH_DIV - 1 : 0);
    localparam logic            C_EN   = (REFRESH_DIV > 0);

    logic [C_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (!C_EN || r_count == C_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = C_EN && (r_count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/lcd_frame_streamer.sv
// lcd_frame_streamer: ROWS x COLS character buffer serialised as LCD command/char bytes.
// Optional macro LCD_CURSOR_OFF_EN prefixes each frame with a display-on/cursor-off command.
`default_nettype none

module lcd_frame_streamer
    import lcd_pkg::*;
#(
    parameter int COLS        = 16,
    parameter int ROWS        = 2,
    parameter int REFRESH_DIV = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic       wr_row,
    input  logic [3:0] wr_col,
    input  logic [7:0] wr_char,
    input  logic       clear,
    input  logic       refresh_req,
    output logic [7:0] out_data,
    output logic       out_is_cmd,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [3:0] C_LAST_COL = 4'(COLS - 1);
    localparam logic       C_LAST_ROW = 1'(ROWS - 1);

    logic [7:0] r_buf [ROWS][COLS];
    state_t     r_state;
    logic       r_row;
    logic [3:0] r_col;
    logic       r_dirty;
    logic [7:0] r_out_data;
    logic       r_out_is_cmd;
    logic       r_out_valid;
    logic       r_busy;
    logic       r_frame_done;

    logic w_tick;
    logic w_wr_ok;
    logic w_xfer;
    logic w_start;

    lcd_refresh_timer #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // clear takes priority over a same-cycle write
    assign w_wr_ok = wr_en && !clear && (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
    assign w_xfer  = r_out_valid && out_ready;
    assign w_start = (r_state == IDLE) && (refresh_req || (w_tick && r_dirty));

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    r_buf[r][c] <= ASCII_SPACE;
                end
            end
        end else if (w_wr_ok) begin
            r_buf[wr_row][wr_col] <= wr_char;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dirty <= 1'b1;
        end else if (clear || w_wr_ok) begin
            r_dirty <= 1'b1;
        end else if (w_start) begin
            r_dirty <= 1'b0;
        end
    end

    // Each byte is loaded while out_valid is low and retired on transfer,
    // so chars are fetched from the buffer at presentation time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_row        <= 1'b0;
            r_col        <= 4'd0;
            r_out_data   <= 8'h00;
            r_out_is_cmd <= 1'b0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_busy  <= 1'b1;
                        r_row   <= 1'b0;
                        r_col   <= 4'd0;
`ifdef LCD_CURSOR_OFF_EN
                        r_state <= DISP_CMD;
`else
                        r_state <= LINE_CMD;
`endif
                    end
                end
`ifdef LCD_CURSOR_OFF_EN
                DISP_CMD: begin
                    if (!r_out_valid) begin
                        r_out_data   <= LCD_CMD_DISP_ON_CUR_OFF;
                        r_out_is_cmd <= 1'b1;
                        r_out_valid  <= 1'b1;
                    end else if (w_xfer) begin
                        r_out_valid  <= 1'b0;
                        r_state      <= LINE_CMD;
                    end
                end
`endif
                LINE_CMD: begin
                    if (!r_out_valid) begin
                        r_out_data   <= line_cmd(r_row);
                        r_out_is_cmd <= 1'b1;
                        r_out_valid  <= 1'b1;
                    end else if (w_xfer) begin
                        r_out_valid  <= 1'b0;
                        r_state      <= CHAR;
                    end
                end
                CHAR: begin
                    if (!r_out_valid) begin
                        r_out_data   <= r_buf[r_row][r_col];
                        r_out_is_cmd <= 1'b0;
                        r_out_valid  <= 1'b1;
                    end else if (w_xfer) begin
                        r_out_valid <= 1'b0;
                        if (r_col != C_LAST_COL) begin
                            r_col <= r_col + 4'd1;
                        end else if (r_row != C_LAST_ROW) begin
                            r_row   <= r_row + 1'b1;
                            r_col   <= 4'd0;
                            r_state <= LINE_CMD;
                        end else begin
                            r_frame_done <= 1'b1;
                            r_busy       <= 1'b0;
                            r_state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign out_data   = r_out_data;
    assign out_is_cmd = r_out_is_cmd;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_lcd_frame_streamer.sv
// tb_lcd_frame_streamer: directed self-checking bench for lcd_frame_streamer.
// Honours LCD_CURSOR_OFF_EN when the design is built with it.
`default_nettype none

module tb_lcd_frame_streamer;

    localparam int COLS = 16;
    localparam int ROWS = 2;
    localparam int DIV  = 200;
`ifdef LCD_CURSOR_OFF_EN
    localparam int HDR  = 1;
`else
    localparam int HDR  = 0;
`endif

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       wr_row;
    logic [3:0] wr_col;
    logic [7:0] wr_char;
    logic       clear;
    logic       refresh_req;
    logic [7:0] out_data;
    logic       out_is_cmd;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       frame_done;

    lcd_frame_streamer #(
        .COLS        (COLS),
        .ROWS        (ROWS),
        .REFRESH_DIV (DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_char     (wr_char),
        .clear       (clear),
        .refresh_req (refresh_req),
        .out_data    (out_data),
        .out_is_cmd  (out_is_cmd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] cap_q[$];
    int         frames = 0;
    int         stall_err = 0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_word = '0;
    logic       rand_ready = 1'b0;
    logic [7:0] mem [ROWS][COLS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transfer monitor: a byte counted here transfers on the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!out_valid || {out_is_cmd, out_data} !== prev_word))
                stall_err++;
            if (out_valid && out_ready)
                cap_q.push_back({out_is_cmd, out_data});
            if (frame_done)
                frames++;
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_is_cmd, out_data};
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic model_spaces();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mem[r][c] = 8'h20;
    endtask

    task automatic wr(input int r, input int c, input logic [7:0] ch);
        wr_en   = 1'b1;
        wr_row  = 1'(r);
        wr_col  = 4'(c);
        wr_char = ch;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        mem[r][c] = ch;
    endtask

    task automatic pulse_refresh();
        refresh_req = 1'b1;
        @(posedge clk);
        #1;
        refresh_req = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input int max_cycles);
        int f0 = frames;
        int n  = 0;
        while (frames == f0 && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({tag, "_done"}, 32'(frames - f0), 32'd1);
    endtask

    task automatic check_frame(input string tag);
        logic [8:0] exp_q[$];
`ifdef LCD_CURSOR_OFF_EN
        exp_q.push_back({1'b1, 8'h0C});
`endif
        for (int r = 0; r < ROWS; r++) begin
            exp_q.push_back({1'b1, (r == 0) ? 8'h80 : 8'hC0});
            for (int c = 0; c < COLS; c++)
                exp_q.push_back({1'b0, mem[r][c]});
        end
        check({tag, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < cap_q.size())
                check($sformatf("%s_b%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
    endtask

    function automatic logic [31:0] cap_at(input int idx);
        return (idx < cap_q.size()) ? 32'(cap_q[idx]) : 32'hFFFF;
    endfunction

    task automatic check_no_frame(input string tag);
        int f0 = frames;
        repeat (2 * DIV + 50) @(posedge clk);
        #1;
        check(tag, 32'(frames), 32'(f0));
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; wr_en = 1'b0; wr_row = 1'b0; wr_col = 4'd0; wr_char = 8'h00;
        clear = 1'b0; refresh_req = 1'b0; out_ready = 1'b1;
        model_spaces();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'h00);
        check("rst_is_cmd", 32'(out_is_cmd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First frame comes only from the timer, since dirty is set out of reset.
        repeat (DIV - 50) @(posedge clk);
        #1;
        check("pre_tick_busy", 32'(busy), 32'd0);
        check("pre_tick_valid", 32'(out_valid), 32'd0);
        wait_frame("auto", 400);
        check_frame("auto");
        check("auto_first", cap_at(0), HDR ? 32'h10C : 32'h180);
        check_no_frame("auto_dirty_clr");

        // Writes plus an explicit refresh; a second refresh mid-frame is ignored.
        cap_q.delete();
        wr(0, 0, 8'h48);
        wr(0, 1, 8'h49);
        pulse_refresh();
        repeat (6) @(posedge clk);
        #1;
        check("hi_busy", 32'(busy), 32'd1);
        pulse_refresh();
        wait_frame("hi", 400);
        check_frame("hi");
        check("hi_H", cap_at(HDR + 1), 32'h048);
        check("hi_I", cap_at(HDR + 2), 32'h049);
        check_no_frame("hi_dirty_clr");

        // Backpressure: ready toggles randomly, output must hold while stalled.
        cap_q.delete();
        stall_err = 0;
        wr(1, 0, 8'h61);
        wr(1, 15, 8'h5A);
        rand_ready = 1'b1;
        pulse_refresh();
        wait_frame("stall", 3000);
        rand_ready = 1'b0;
        #2;
        out_ready = 1'b1;
        check_frame("stall");
        check("stall_stable", 32'(stall_err), 32'd0);

        // clear and write in the same cycle: clear wins.
        cap_q.delete();
        clear = 1'b1; wr_en = 1'b1; wr_row = 1'b1; wr_col = 4'd5; wr_char = 8'h41;
        @(posedge clk);
        #1;
        clear = 1'b0; wr_en = 1'b0;
        model_spaces();
        pulse_refresh();
        wait_frame("clr", 400);
        check_frame("clr");
        check("clr_r1c5", cap_at(HDR + COLS + 2 + 5), 32'h020);

        // Reset partway through a frame.
        wr(0, 3, 8'h51);
        cap_q.delete();
        pulse_refresh();
        n = 0;
        while (cap_q.size() < 10 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("mid_reached10", 32'(cap_q.size() >= 10), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'h00);
        model_spaces();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cap_q.delete();
        wait_frame("post_rst", 500);
        check_frame("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lcd_frame_streamer.md
Name: lcd_frame_streamer

Overview:
- Upstream feeder for the 4-bit text LCD driver.
- Holds a ROWS x COLS character frame buffer written by game/control logic.
- Serialises the buffer into a byte stream of LCD commands and ASCII characters, using a valid/ready handshake.
- The downstream driver consumes one byte per transfer and nibble-splits it.

Parameters:
COLS, 16, characters per line.
ROWS, 2, display lines (1 or 2 supported).
REFRESH_DIV, 5000000, clk cycles between automatic refresh checks (0 disables auto refresh).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
wr_en  input  1  write one character into buffer this cycle
wr_row  input  1  target row (0..ROWS-1)
wr_col  input  4  target column (0..COLS-1)
wr_char  input  8  ASCII character to store
clear  input  1  fill entire buffer with 0x20 this cycle
refresh_req  input  1  request an immediate frame stream
out_data  output  8  byte to LCD driver
out_is_cmd  output  1  1 = command byte (RS=0), 0 = character (RS=1)
out_valid  output  1  out_data/out_is_cmd valid
out_ready  input  1  downstream accepts byte when high with out_valid
busy  output  1  frame stream in progress
frame_done  output  1  one-cycle pulse after the last byte of a frame transfers

Behaviour:
- Reset values:
  - buffer all 0x20; dirty=1 (first frame streams after reset).
  - out_valid=0, out_data=0x00, out_is_cmd=0, busy=0, frame_done=0, state IDLE, timer=0.
- Buffer writes:
  - Synchronous, one cycle, in any state.
  - Out-of-range row/col is ignored (no write, dirty unchanged).
  - clear and wr_en in the same cycle: clear wins and the write is dropped.
  - Any accepted write or clear sets dirty.
- Handshake:
  - A transfer occurs on a rising edge with out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data/out_is_cmd stay stable.
  - out_valid never drops without a transfer, except on reset.
- Start condition, evaluated in IDLE:
  - refresh_req=1, or
  - the timer wraps at REFRESH_DIV-1 while dirty=1.
- FSM states:
  - IDLE: on start, clear dirty, go to LINE_CMD with row=0, col=0; busy=1 from the next cycle.
  - LINE_CMD: present out_data = 0x80 | (row ? 0x40 : 0x00), out_is_cmd=1; on transfer go to CHAR.
  - CHAR: present buffer[row][col], out_is_cmd=0. On transfer:
    - col<COLS-1: col++.
    - col==COLS-1 and row<ROWS-1: row++, col=0, go to LINE_CMD.
    - last cell: go to DONE.
  - DONE: out_valid=0, frame_done=1 for one cycle, busy=0, return to IDLE.
- Data timing:
  - Characters are read live at presentation time, so a write to a not-yet-sent cell appears in this frame.
  - A write during streaming re-sets dirty, so a follow-up frame occurs on the next timer wrap.
- refresh_req while busy is ignored.
- Next valid byte is presented in the cycle after a transfer (registered outputs, 1-cycle bubble between bytes is acceptable).
- Transfer count per frame (no optional feature): ROWS*(COLS+1) = 34 with defaults.
- Reset mid-frame: outputs return to reset values immediately, buffer returns to spaces, dirty=1.

Optional Feature:
- Macro: LCD_CURSOR_OFF_EN.
- Defined:
  - Each frame begins with state DISP_CMD emitting out_data=0x0C, out_is_cmd=1 (display on, cursor off, blink off) before the row-0 LINE_CMD.
  - Frame = 35 transfers.
- Undefined:
  - DISP_CMD state is absent; frame starts at LINE_CMD.
  - Frame = 34 transfers.

Decomposition:
- Shared package lcd_pkg contains:
  - state enum: IDLE, DISP_CMD, LINE_CMD, CHAR, DONE.
  - constants LCD_CMD_LINE0=8'h80, LCD_CMD_LINE1=8'hC0, LCD_CMD_DISP_ON_CUR_OFF=8'h0C, ASCII_SPACE=8'h20.
- One sub-module is natural: lcd_refresh_timer (free-running counter, REFRESH_DIV parameter, one-cycle tick output).

Test Plan:
- Release reset, out_ready=1 -> frame auto-starts at the first timer tick: 0x80(cmd), 16x 0x20, 0xC0(cmd), 16x 0x20, frame_done pulse; 34 transfers.
- Write "HI" at row0 col0/1, pulse refresh_req -> bytes 2-3 are 0x48, 0x49; rest spaces; dirty clear afterwards.
- Stream with out_ready toggling 1-0-0-1 pseudo-randomly -> no byte lost or duplicated, out_data stable while stalled.
- clear and wr_en(row1,col5,'A') in the same cycle -> buffer all 0x20, row1 col5 == 0x20.
- Assert rst at transfer 10 -> out_valid=0 and busy=0 immediately; next frame all spaces.
- With LCD_CURSOR_OFF_EN defined, pulse refresh_req -> first byte 0x0C cmd, 35 transfers total.
